ddmtd_lock_sequencer: RTL and testbench
=======================================

// Module: ddmtd_lock_sequencer
// PURPOSE
//  Acquisition/tracking controller for the DDMTD helper-PLL loop: sequences loop-filter clear,
//  loop closure and kp/ki gain selection from beat-domain phase-error measurements.
//  Sits beside the sampler/loop_filter/NCO chain; drives sel_close, kp_sel, ki_sel, lf_clear.
// PARAMETERS
//  ERR_W       16      width of signed phase_err
//  CLEAR_CYC   16      cycles lf_clear is held in CLEAR (>=1)
//  ACQ_TOL     256     |err| window counted as in-lock during ACQ
//  TRK_TOL     64      |err| window tolerated during TRACK
//  LOCK_CNT    8       consecutive in-window samples ACQ->TRACK
//  UNLOCK_CNT  4       consecutive out-of-window samples TRACK->ACQ
//  ACQ_TIMEOUT 1024    phase_valid samples allowed per ACQ attempt
//  MAX_RETRY   3       ACQ attempts before FAIL
//  ACQ_KP/ACQ_KI 2'b11/2'b10  gains in ACQ;  TRK_KP/TRK_KI 2'b01/2'b00  gains in TRACK
//  WDOG_CYC    65535   watchdog limit in clk cycles (LOCK_WDOG_EN only)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  ena          in   1      block enable; 0 freezes all state/counters, outputs hold
//  start        in   1      begin acquisition (level, sampled each cycle)
//  stop         in   1      abort to IDLE
//  phase_valid  in   1      one-cycle measurement strobe
//  phase_err    in   ERR_W  signed phase error, valid with phase_valid
//  sel_close    out  1      1 = loop closed on internal helper
//  lf_clear     out  1      loop-filter integrator clear
//  kp_sel       out  2      P gain select
//  ki_sel       out  2      I gain select
//  locked       out  1      1 in TRACK only
//  fail         out  1      1 in FAIL only
//  lock_lost    out  1      sticky: set on any TRACK->ACQ, cleared by rst or start in IDLE/FAIL
//  state        out  3      IDLE=0 CLEAR=1 ACQ=2 TRACK=3 FAIL=4
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, sel_close=0, lf_clear=0, kp_sel=ki_sel=00,
//    locked=0, fail=0, lock_lost=0, all counters 0. rst wins over everything, including ena=0.
//  - abs: |err| computed in ERR_W bits; -2^(ERR_W-1) saturates to 2^(ERR_W-1)-1. Compare <=TOL.
//  - IDLE: sel_close=0, gains 00. start -> CLEAR, retry_cnt=0.
//  - CLEAR: lf_clear=1, sel_close=0, gains 00 for exactly CLEAR_CYC cycles, then ACQ.
//  - ACQ: sel_close=1, gains ACQ_*. Each phase_valid: in-window -> ok_cnt++, else ok_cnt=0;
//    samp_cnt++. ok_cnt reaching LOCK_CNT -> TRACK (same cycle as the LOCK_CNT-th sample).
//    samp_cnt reaching ACQ_TIMEOUT without lock: retry_cnt++; if retry_cnt==MAX_RETRY -> FAIL,
//    else -> CLEAR. Lock wins if both on the same sample.
//  - TRACK: sel_close=1, gains TRK_*, locked=1. Out-of-TRK_TOL sample -> bad_cnt++, in-window
//    sample -> bad_cnt=0. bad_cnt reaching UNLOCK_CNT -> ACQ (no clear, retry_cnt=0), lock_lost=1.
//  - FAIL: sel_close=0, gains 00, fail=1. start -> CLEAR with retry_cnt=0; stop -> IDLE.
//  - stop in any non-IDLE state -> IDLE next cycle; stop beats start when both high.
//  - ok_cnt/bad_cnt/samp_cnt cleared on every state entry; phase_valid arriving in the
//    transition cycle is evaluated by the old state only. Counters saturate, never wrap.
//  - Outputs change one cycle after the causing input (single-cycle decision latency).
//  - ena=0 mid-operation: no state change, counters and outputs held; resume on ena=1.
// CONFIGURATION
//  LOCK_WDOG_EN defined: cycle counter reset by each phase_valid and on state entry; in ACQ or
//    TRACK, WDOG_CYC cycles with no phase_valid -> CLEAR, retry_cnt++ (FAIL at MAX_RETRY),
//    lock_lost=1 if from TRACK. Not defined: no watchdog logic; missing strobes stall the FSM.
// TESTING
//  1 rst=1 2 cycles -> all outputs 0, state=0; start=1 -> state 1, lf_clear=1 for 16 cycles, then state 2.
//  2 ACQ, 8 strobes err=+100 -> state 3, locked=1, kp=01 ki=00; 7 in-window + err=-300 -> ok resets, no lock.
//  3 TRACK, 4 strobes err=+65 -> state 2, lock_lost=1, locked=0; 3 bad + 1 err=10 -> stays TRACK.
//  4 ACQ, err=0x8000 on 1024 strobes x3 attempts -> CLEAR twice then state 4, fail=1; start -> CLEAR.
//  5 start=stop=1 in IDLE -> stays IDLE; stop in TRACK -> IDLE, sel_close=0 next cycle; ena=0 freezes counts.
//  6 LOCK_WDOG_EN, WDOG_CYC=100, TRACK with no strobes 100 cycles -> CLEAR, lock_lost=1.

Source files
------------

// File: rtl/ddmtd_lock_sequencer_if.sv
// ----------------------------------------------------------------------------
// ddmtd_lock_sequencer_if
// Control/status bundle between the DDMTD lock sequencer and its surroundings.
//
// Signals
//   ena          block enable (0 freezes the sequencer)
//   start        begin acquisition (level)
//   stop         abort to IDLE
//   phase_valid  one-cycle measurement strobe
//   phase_err    signed phase error, ERR_W bits, valid with phase_valid
//   sel_close    loop closed on internal helper
//   lf_clear     loop-filter integrator clear
//   kp_sel       P gain select
//   ki_sel       I gain select
//   locked       high in TRACK
//   fail         high in FAIL
//   lock_lost    sticky loss-of-lock flag
//   state        current sequencer state code
//
// Modports
//   master  drives the control inputs, observes status (host / bench side)
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface ddmtd_lock_sequencer_if #(
    parameter int ERR_W = 16
);
    logic                    ena;
    logic                    start;
    logic                    stop;
    logic                    phase_valid;
    logic signed [ERR_W-1:0] phase_err;

    logic                    sel_close;
    logic                    lf_clear;
    logic [1:0]              kp_sel;
    logic [1:0]              ki_sel;
    logic                    locked;
    logic                    fail;
    logic                    lock_lost;
    logic [2:0]              state;

    modport master (
        output ena, start, stop, phase_valid, phase_err,
        input  sel_close, lf_clear, kp_sel, ki_sel, locked, fail, lock_lost, state
    );

    modport slave (
        input  ena, start, stop, phase_valid, phase_err,
        output sel_close, lf_clear, kp_sel, ki_sel, locked, fail, lock_lost, state
    );
endinterface

// File: rtl/ddmtd_lock_sequencer.sv
// ----------------------------------------------------------------------------
// ddmtd_lock_sequencer
// Acquisition/tracking controller for the DDMTD helper-PLL loop. Clears the
// loop filter, closes the loop with acquisition gains, switches to tracking
// gains once the phase error stays inside the acquisition window, and falls
// back to acquisition when the error leaves the tracking window.
//
// Ports
//   clk   system clock
//   rst   synchronous reset, active-high (wins over ena=0)
//   bus   ddmtd_lock_sequencer_if.slave
//           in : ena, start, stop, phase_valid, phase_err
//           out: sel_close, lf_clear, kp_sel, ki_sel, locked, fail,
//                lock_lost, state
//
// Optional feature
//   LOCK_WDOG_EN  when defined, adds a strobe watchdog: WDOG_CYC cycles in
//                 ACQ or TRACK without phase_valid count as a failed attempt
//                 and send the loop back through CLEAR. The WDOG_CYC
//                 parameter only exists in that build.
// ----------------------------------------------------------------------------
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | loop open, gains 00, waiting for start
// CLEAR | loop open, lf_clear held for CLEAR_CYC cycles
// ACQ   | loop closed, acquisition gains, counting in-window samples
// TRACK | loop closed, tracking gains, locked=1, counting bad samples
// FAIL  | loop open, fail=1 after MAX_RETRY timed-out attempts
// ----------------------------------------------------------------------------
module ddmtd_lock_sequencer #(
    parameter int         ERR_W       = 16,
    parameter int         CLEAR_CYC   = 16,
    parameter int         ACQ_TOL     = 256,
    parameter int         TRK_TOL     = 64,
    parameter int         LOCK_CNT    = 8,
    parameter int         UNLOCK_CNT  = 4,
    parameter int         ACQ_TIMEOUT = 1024,
    parameter int         MAX_RETRY   = 3,
    parameter logic [1:0] ACQ_KP      = 2'b11,
    parameter logic [1:0] ACQ_KI      = 2'b10,
    parameter logic [1:0] TRK_KP      = 2'b01,
    parameter logic [1:0] TRK_KI      = 2'b00
`ifdef LOCK_WDOG_EN
    ,
    parameter int         WDOG_CYC    = 65535
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    ddmtd_lock_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACQ   = 3'd2,
        ST_TRACK = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    localparam int OK_W   = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam int SAMP_W = $clog2(ACQ_TIMEOUT + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);
    localparam int CLR_W  = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;

    localparam logic [OK_W-1:0]   LOCK_V  = OK_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  UNL_V   = BAD_W'(UNLOCK_CNT);
    localparam logic [SAMP_W-1:0] SAMP_V  = SAMP_W'(ACQ_TIMEOUT);
    localparam logic [RTY_W-1:0]  RTY_V   = RTY_W'(MAX_RETRY);
    // CLEAR timer counts down to zero; the terminal cycle is the last one
    // with lf_clear asserted, giving exactly CLEAR_CYC cycles in CLEAR.
    localparam logic [CLR_W-1:0]  CLR_LD  = CLR_W'(CLEAR_CYC - 1);

    localparam logic [ERR_W-1:0]  ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0]  ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0]  ACQ_TOL_V = ERR_W'(ACQ_TOL);
    localparam logic [ERR_W-1:0]  TRK_TOL_V = ERR_W'(TRK_TOL);

`ifdef LOCK_WDOG_EN
    localparam int                WDG_W  = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WDG_W-1:0]  WDG_LD = WDG_W'(WDOG_CYC - 1);
`endif

    state_t              state_q,  state_nxt;
    logic [OK_W-1:0]     ok_q,     ok_nxt,    ok_inc;
    logic [BAD_W-1:0]    bad_q,    bad_nxt,   bad_inc;
    logic [SAMP_W-1:0]   samp_q,   samp_nxt,  samp_inc;
    logic [RTY_W-1:0]    retry_q,  retry_nxt, retry_inc;
    logic [CLR_W-1:0]    clr_q,    clr_nxt;
    logic                lost_q,   lost_nxt;
`ifdef LOCK_WDOG_EN
    logic [WDG_W-1:0]    wdog_q,   wdog_nxt;
`endif

    logic                sel_close_q, sel_close_nxt;
    logic                lf_clear_q,  lf_clear_nxt;
    logic [1:0]          kp_q,        kp_nxt;
    logic [1:0]          ki_q,        ki_nxt;
    logic                locked_q,    locked_nxt;
    logic                fail_q,      fail_nxt;

    logic [ERR_W-1:0]    err_raw;
    logic [ERR_W-1:0]    err_abs;
    logic                in_acq;
    logic                in_trk;

    // Magnitude in ERR_W bits; the most negative code has no positive
    // counterpart and is clamped to the largest positive value.
    assign err_raw = bus.phase_err;

    always_comb begin
        if (err_raw == ERR_MIN) begin
            err_abs = ERR_MAX;
        end else if (err_raw[ERR_W-1]) begin
            err_abs = -err_raw;
        end else begin
            err_abs = err_raw;
        end
    end

    assign in_acq = (err_abs <= ACQ_TOL_V);
    assign in_trk = (err_abs <= TRK_TOL_V);

    // Saturating increments.
    assign ok_inc    = (ok_q    == LOCK_V) ? ok_q    : ok_q    + OK_W'(1);
    assign bad_inc   = (bad_q   == UNL_V)  ? bad_q   : bad_q   + BAD_W'(1);
    assign samp_inc  = (samp_q  == SAMP_V) ? samp_q  : samp_q  + SAMP_W'(1);
    assign retry_inc = (retry_q == RTY_V)  ? retry_q : retry_q + RTY_W'(1);

    // ------------------------------------------------------------------
    // Next-state, counter and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        ok_nxt    = ok_q;
        bad_nxt   = bad_q;
        samp_nxt  = samp_q;
        retry_nxt = retry_q;
        clr_nxt   = clr_q;
        lost_nxt  = lost_q;
`ifdef LOCK_WDOG_EN
        wdog_nxt  = wdog_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nxt = ST_CLEAR;
                    retry_nxt = '0;
                    lost_nxt  = 1'b0;
                end
            end

            ST_CLEAR: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (clr_q == '0) begin
                    state_nxt = ST_ACQ;
                end else begin
                    clr_nxt = clr_q - CLR_W'(1);
                end
            end

            ST_ACQ: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.phase_valid) begin
                    ok_nxt   = in_acq ? ok_inc : '0;
                    samp_nxt = samp_inc;
                    // Lock is checked first so it wins over a coincident timeout.
                    if (in_acq && (ok_inc == LOCK_V)) begin
                        state_nxt = ST_TRACK;
                    end else if (samp_inc == SAMP_V) begin
                        retry_nxt = retry_inc;
                        state_nxt = (retry_inc == RTY_V) ? ST_FAIL : ST_CLEAR;
                    end
                end
`ifdef LOCK_WDOG_EN
                else if (wdog_q == '0) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RTY_V) ? ST_FAIL : ST_CLEAR;
                end
`endif
            end

            ST_TRACK: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.phase_valid) begin
                    bad_nxt = in_trk ? '0 : bad_inc;
                    if (!in_trk && (bad_inc == UNL_V)) begin
                        state_nxt = ST_ACQ;
                        retry_nxt = '0;
                        lost_nxt  = 1'b1;
                    end
                end
`ifdef LOCK_WDOG_EN
                else if (wdog_q == '0) begin
                    retry_nxt = retry_inc;
                    lost_nxt  = 1'b1;
                    state_nxt = (retry_inc == RTY_V) ? ST_FAIL : ST_CLEAR;
                end
`endif
            end

            ST_FAIL: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    state_nxt = ST_CLEAR;
                    retry_nxt = '0;
                    lost_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

`ifdef LOCK_WDOG_EN
        if (bus.phase_valid) begin
            wdog_nxt = WDG_LD;
        end else if ((state_q == ST_ACQ || state_q == ST_TRACK) && wdog_q != '0) begin
            wdog_nxt = wdog_q - WDG_W'(1);
        end
`endif

        // Every state entry starts the per-state counters afresh.
        if (state_nxt != state_q) begin
            ok_nxt   = '0;
            bad_nxt  = '0;
            samp_nxt = '0;
            clr_nxt  = CLR_LD;
`ifdef LOCK_WDOG_EN
            wdog_nxt = WDG_LD;
`endif
        end

        // Outputs are decoded from the next state and registered, so they
        // follow the causing input by exactly one cycle.
        sel_close_nxt = (state_nxt == ST_ACQ) || (state_nxt == ST_TRACK);
        lf_clear_nxt  = (state_nxt == ST_CLEAR);
        locked_nxt    = (state_nxt == ST_TRACK);
        fail_nxt      = (state_nxt == ST_FAIL);
        kp_nxt        = 2'b00;
        ki_nxt        = 2'b00;
        if (state_nxt == ST_ACQ) begin
            kp_nxt = ACQ_KP;
            ki_nxt = ACQ_KI;
        end else if (state_nxt == ST_TRACK) begin
            kp_nxt = TRK_KP;
            ki_nxt = TRK_KI;
        end
    end

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ok_q        <= '0;
            bad_q       <= '0;
            samp_q      <= '0;
            retry_q     <= '0;
            clr_q       <= '0;
            lost_q      <= 1'b0;
`ifdef LOCK_WDOG_EN
            wdog_q      <= '0;
`endif
            sel_close_q <= 1'b0;
            lf_clear_q  <= 1'b0;
            kp_q        <= 2'b00;
            ki_q        <= 2'b00;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else if (bus.ena) begin
            state_q     <= state_nxt;
            ok_q        <= ok_nxt;
            bad_q       <= bad_nxt;
            samp_q      <= samp_nxt;
            retry_q     <= retry_nxt;
            clr_q       <= clr_nxt;
            lost_q      <= lost_nxt;
`ifdef LOCK_WDOG_EN
            wdog_q      <= wdog_nxt;
`endif
            sel_close_q <= sel_close_nxt;
            lf_clear_q  <= lf_clear_nxt;
            kp_q        <= kp_nxt;
            ki_q        <= ki_nxt;
            locked_q    <= locked_nxt;
            fail_q      <= fail_nxt;
        end
    end

    assign bus.sel_close = sel_close_q;
    assign bus.lf_clear  = lf_clear_q;
    assign bus.kp_sel    = kp_q;
    assign bus.ki_sel    = ki_q;
    assign bus.locked    = locked_q;
    assign bus.fail      = fail_q;
    assign bus.lock_lost = lost_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_ddmtd_lock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ddmtd_lock_sequencer
// Self-checking bench for ddmtd_lock_sequencer. A behavioural model tracks
// the expected state code and flags from the sequencing rules; every cycle
// the DUT outputs are compared with it, and directed scenarios add explicit
// expectations at the interesting points. Define LOCK_WDOG_EN to build the
// watchdog variant (WDOG_CYC=100) and its scenario.
// ----------------------------------------------------------------------------
module tb_ddmtd_lock_sequencer;

    localparam int CLEAR_CYC   = 16;
    localparam int ACQ_TOL     = 256;
    localparam int TRK_TOL     = 64;
    localparam int LOCK_CNT    = 8;
    localparam int UNLOCK_CNT  = 4;
    localparam int ACQ_TIMEOUT = 1024;
    localparam int MAX_RETRY   = 3;
    localparam int WDOG_CYC    = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddmtd_lock_sequencer_if #(.ERR_W(16)) bus ();

`ifdef LOCK_WDOG_EN
    ddmtd_lock_sequencer #(.WDOG_CYC(WDOG_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    ddmtd_lock_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model
    int m_state;      // spec state code 0..4
    int m_clr_left;   // CLEAR cycles still to spend
    int m_ok;         // consecutive in-window samples in ACQ
    int m_bad;        // consecutive out-of-window samples in TRACK
    int m_samp;       // samples seen in this ACQ attempt
    int m_retry;      // timed-out attempts so far
    int m_quiet;      // cycles without a strobe (watchdog build)
    bit m_lost;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mag(input int err);
        int a;
        a = (err < 0) ? -err : err;
        return (a > 32767) ? 32767 : a;
    endfunction

    task automatic model_reset();
        m_state = 0; m_clr_left = 0; m_ok = 0; m_bad = 0;
        m_samp = 0; m_retry = 0; m_quiet = 0; m_lost = 0;
    endtask

    task automatic model_step(input bit en, input bit st, input bit sp, input bit pv, input int err);
        int a;
        int nxt;
        if (!en) return;
        a   = mag(err);
        nxt = m_state;
        if (pv) m_quiet = 0;
        case (m_state)
            0: if (st && !sp) begin nxt = 1; m_retry = 0; m_lost = 0; end
            1: begin
                if (sp) nxt = 0;
                else begin
                    m_clr_left--;
                    if (m_clr_left == 0) nxt = 2;
                end
            end
            2: begin
                if (sp) nxt = 0;
                else if (pv) begin
                    m_ok = (a <= ACQ_TOL) ? m_ok + 1 : 0;
                    m_samp++;
                    if (m_ok >= LOCK_CNT) nxt = 3;
                    else if (m_samp >= ACQ_TIMEOUT) begin
                        m_retry++;
                        nxt = (m_retry >= MAX_RETRY) ? 4 : 1;
                    end
                end
`ifdef LOCK_WDOG_EN
                else begin
                    m_quiet++;
                    if (m_quiet >= WDOG_CYC) begin
                        m_retry++;
                        nxt = (m_retry >= MAX_RETRY) ? 4 : 1;
                    end
                end
`endif
            end
            3: begin
                if (sp) nxt = 0;
                else if (pv) begin
                    m_bad = (a > TRK_TOL) ? m_bad + 1 : 0;
                    if (m_bad >= UNLOCK_CNT) begin nxt = 2; m_retry = 0; m_lost = 1; end
                end
`ifdef LOCK_WDOG_EN
                else begin
                    m_quiet++;
                    if (m_quiet >= WDOG_CYC) begin
                        m_retry++;
                        m_lost = 1;
                        nxt = (m_retry >= MAX_RETRY) ? 4 : 1;
                    end
                end
`endif
            end
            default: begin
                if (sp) nxt = 0;
                else if (st) begin nxt = 1; m_retry = 0; m_lost = 0; end
            end
        endcase
        if (nxt != m_state) begin
            m_ok = 0; m_bad = 0; m_samp = 0; m_quiet = 0;
            m_clr_left = CLEAR_CYC;
        end
        m_state = nxt;
    endtask

    task automatic compare_all();
        check("state",     32'(bus.state),     32'(m_state));
        check("sel_close", 32'(bus.sel_close), 32'(m_state == 2 || m_state == 3));
        check("lf_clear",  32'(bus.lf_clear),  32'(m_state == 1));
        check("kp_sel",    32'(bus.kp_sel),    (m_state == 2) ? 32'd3 : (m_state == 3) ? 32'd1 : 32'd0);
        check("ki_sel",    32'(bus.ki_sel),    (m_state == 2) ? 32'd2 : 32'd0);
        check("locked",    32'(bus.locked),    32'(m_state == 3));
        check("fail",      32'(bus.fail),      32'(m_state == 4));
        check("lock_lost", 32'(bus.lock_lost), 32'(m_lost));
    endtask

    // One clock: drive, let the DUT sample, advance the model, compare.
    task automatic cycle(input bit en, input bit st, input bit sp, input bit pv, input int err);
        bus.ena = en; bus.start = st; bus.stop = sp;
        bus.phase_valid = pv; bus.phase_err = 16'(err);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(en, st, sp, pv, err);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
    endtask

    task automatic strobe(input int err);
        cycle(1, 0, 0, 1, err);
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        for (int i = 0; i < budget && bus.state != 3'(s); i++) cycle(1, 0, 0, 0, 0);
        check(tag, 32'(bus.state), 32'(s));
    endtask

    function automatic int rand_in(input int tol);
        return int'($urandom_range(0, 2 * tol)) - tol;
    endfunction

    function automatic int rand_out(input int tol);
        int m;
        m = int'($urandom_range(tol + 1, 32767));
        return $urandom_range(0, 1) ? m : -m;
    endfunction

    function automatic int rand_err();
        int edges [8];
        edges = '{64, 65, -64, -65, 256, 257, -256, -257};
        case ($urandom_range(0, 6))
            0, 1:    return rand_in(TRK_TOL);
            2, 3:    return rand_in(ACQ_TOL);
            4:       return edges[$urandom_range(0, 7)];
            5:       return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        int clears;
        logic [2:0] prev;
        bus.ena = 0; bus.start = 0; bus.stop = 0; bus.phase_valid = 0; bus.phase_err = '0;
        model_reset();

        // reset wins over ena=0, with busy inputs
        rst = 1'b1;
        cycle(0, 1, 0, 1, 5);
        cycle(0, 1, 0, 1, 5);
        check("rst_state", 32'(bus.state), 0);
        check("rst_outs", 32'({bus.sel_close, bus.lf_clear, bus.kp_sel, bus.ki_sel,
                               bus.locked, bus.fail, bus.lock_lost}), 0);
        rst = 1'b0;

        // start -> CLEAR for exactly CLEAR_CYC cycles -> ACQ
        cycle(1, 1, 0, 0, 0);
        check("clr_entry", 32'(bus.state), 1);
        check("clr_lf", 32'(bus.lf_clear), 1);
        idle(CLEAR_CYC - 1);
        check("clr_last", 32'(bus.state), 1);
        idle(1);
        check("acq_entry", 32'(bus.state), 2);
        check("acq_gain", 32'({bus.kp_sel, bus.ki_sel}), 32'h0E);

        // 7 in-window (edges of window included) then out-of-window -> no lock
        strobe(256); strobe(-256);
        for (int i = 0; i < 5; i++) strobe(rand_in(ACQ_TOL));
        strobe(-300);
        check("acq_oknolock", 32'(bus.state), 2);
        for (int i = 0; i < 7; i++) begin
            strobe(100);
            idle($urandom_range(0, 3));
        end
        check("acq_seven", 32'(bus.state), 2);
        strobe(100);
        check("lock_state", 32'(bus.state), 3);
        check("lock_gain", 32'({bus.locked, bus.kp_sel, bus.ki_sel}), 32'h14);

        // TRACK: bad runs broken by in-window samples keep lock
        strobe(65); strobe(65); strobe(65); strobe(10);
        check("trk_hold1", 32'(bus.state), 3);
        for (int i = 0; i < 3; i++) strobe(rand_out(TRK_TOL));
        strobe(64);
        check("trk_hold2", 32'(bus.state), 3);
        for (int i = 0; i < UNLOCK_CNT; i++) begin
            strobe(65);
            idle($urandom_range(0, 2));
        end
        check("unlock_state", 32'(bus.state), 2);
        check("unlock_lost", 32'(bus.lock_lost), 1);
        check("unlock_locked", 32'(bus.locked), 0);

        // repeated timeouts with the most negative error -> FAIL
        clears = 0;
        prev = bus.state;
        for (int i = 0; i < 4000 && bus.state != 3'd4; i++) begin
            cycle(1, 0, 0, 1, -32768);
            if (bus.state == 3'd1 && prev != 3'd1) clears++;
            prev = bus.state;
        end
        check("to_clears", 32'(clears), 2);
        check("to_fail", 32'({bus.state, bus.fail, bus.sel_close}), 32'b100_1_0);
        cycle(1, 1, 0, 0, 0);
        check("fail_restart", 32'(bus.state), 1);
        check("restart_lost", 32'(bus.lock_lost), 0);

        // stop handling
        cycle(1, 0, 1, 0, 0);
        check("stop_clear", 32'(bus.state), 0);
        cycle(1, 1, 1, 0, 0);
        check("stop_beats", 32'(bus.state), 0);
        cycle(1, 1, 0, 0, 0);
        wait_state(2, 40, "reacq");
        for (int i = 0; i < LOCK_CNT; i++) strobe(rand_in(ACQ_TOL));
        check("relock", 32'(bus.state), 3);
        cycle(1, 0, 1, 1, 5000);
        check("stop_trk", 32'({bus.state, bus.sel_close}), 0);

        // ena=0 freezes ACQ counting
        cycle(1, 1, 0, 0, 0);
        wait_state(2, 40, "frz_acq");
        for (int i = 0; i < 5; i++) strobe(rand_in(ACQ_TOL));
        for (int i = 0; i < 10; i++) cycle(0, 0, (i == 4), 1, rand_out(ACQ_TOL));
        check("frz_hold", 32'(bus.state), 2);
        for (int i = 0; i < 3; i++) strobe(rand_in(ACQ_TOL));
        check("frz_lock", 32'(bus.state), 3);

`ifdef LOCK_WDOG_EN
        // no strobes in TRACK -> watchdog sends the loop back through CLEAR
        idle(WDOG_CYC - 1);
        check("wdog_pre", 32'(bus.state), 3);
        idle(1);
        check("wdog_trip", 32'(bus.state), 1);
        check("wdog_lost", 32'(bus.lock_lost), 1);
`endif

        // randomized soak against the model
        rst = 1'b1;
        cycle(1, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            cycle($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 60, rand_err());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
